// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller with HI/LO registers and fixed-latency busy window
// Results are computed at accept time and committed to HI/LO when the latency counter expires.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  HILOCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  input  logic        DUseMDU,
  output logic        Busy,
  output logic        StallReq,
  output logic [31:0] HILOOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] thi_q, thi_d;
  logic [31:0] tlo_q, tlo_d;

  logic        accept;
  logic [63:0] a_sx, b_sx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        div_ovf;

  always_comb begin
    a_sx    = {{32{A[31]}}, A};
    b_sx    = {{32{B[31]}}, B};
    prod_s  = a_sx * b_sx;
    prod_u  = {32'd0, A} * {32'd0, B};
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    quot_s  = 32'd0;
    rem_s   = 32'd0;
    quot_u  = 32'd0;
    rem_u   = 32'd0;
    if (B != 32'd0) begin
      quot_u = A / B;
      rem_u  = A % B;
      // The one signed overflow case is pinned explicitly rather than left to the divider.
      if (div_ovf) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = $signed(A) / $signed(B);
        rem_s  = $signed(A) % $signed(B);
      end
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) && Start && !Req &&
              (HILOCtrl >= OP_MULT) && (HILOCtrl <= OP_DIVU);
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = (HILOCtrl <= OP_MULTU) ? 4'(MULT_CYC) : 4'(DIV_CYC);
          // Divide by zero commits the current HI/LO, which cannot change while RUN.
          thi_d   = hi_q;
          tlo_d   = lo_q;
          case (HILOCtrl)
            OP_MULT:  begin thi_d = prod_s[63:32]; tlo_d = prod_s[31:0]; end
            OP_MULTU: begin thi_d = prod_u[63:32]; tlo_d = prod_u[31:0]; end
            OP_DIV:   if (B != 32'd0) begin thi_d = rem_s; tlo_d = quot_s; end
            default:  if (B != 32'd0) begin thi_d = rem_u; tlo_d = quot_u; end
          endcase
        end else if (!Req && HILOCtrl == OP_MTHI) begin
          hi_d = A;
        end else if (!Req && HILOCtrl == OP_MTLO) begin
          lo_d = A;
        end
      end
      default: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          hi_d    = thi_q;
          lo_d    = tlo_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      thi_q   <= 32'd0;
      tlo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
    end
  end

  always_comb begin
    Busy     = (state_q == RUN);
    StallReq = DUseMDU & (Busy | Start);
    HI       = hi_q;
    LO       = lo_q;
    HILOOut  = 32'd0;
    if (HILOCtrl == OP_MFHI) HILOOut = hi_q;
    else if (HILOCtrl == OP_MFLO) HILOOut = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and randomized checks of mdu_ctrl against an arithmetic model
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, Start, Req, DUseMDU;
  logic [3:0]  HILOCtrl;
  logic [31:0] A, B;
  logic        Busy, StallReq;
  logic [31:0] HILOOut, HI, LO;

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .HILOCtrl(HILOCtrl), .A(A), .B(B),
    .Req(Req), .DUseMDU(DUseMDU), .Busy(Busy), .StallReq(StallReq),
    .HILOOut(HILOOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: remaining busy cycles plus the pending result to commit when they run out.
  int          m_left  = 0;
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          busy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu, uq, ur;
    sa = longint'($signed(A));
    sb = longint'($signed(B));
    ua = {32'd0, A};
    ub = {32'd0, B};
    if (reset) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      m_pend  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (Start && !Req && HILOCtrl >= 1 && HILOCtrl <= 4) begin
      m_left = (HILOCtrl <= 2) ? 5 : 10;
      m_pend = 1'b1;
      case (HILOCtrl)
        4'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; end
        4'd2: begin pu = ua * ub; m_phi = pu[63:32]; m_plo = pu[31:0]; end
        4'd3: if (B == 0) m_pend = 1'b0;
              else begin q = sa / sb; r = sa % sb; m_phi = r[31:0]; m_plo = q[31:0]; end
        default: if (B == 0) m_pend = 1'b0;
              else begin uq = ua / ub; ur = ua % ub; m_phi = ur[31:0]; m_plo = uq[31:0]; end
      endcase
    end else if (!Req && HILOCtrl == 5) begin
      m_hi = A;
    end else if (!Req && HILOCtrl == 6) begin
      m_lo = A;
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic rq, input logic du);
    logic [31:0] exp_out;
    reset = r; Start = st; HILOCtrl = op; A = a; B = b; Req = rq; DUseMDU = du;
    #4;
    if (Busy) busy_seen++;
    if (m_valid) begin
      exp_out = (op == 7) ? m_hi : (op == 8) ? m_lo : 32'd0;
      check("busy",     {31'd0, Busy},     {31'd0, m_left > 0});
      check("stallreq", {31'd0, StallReq}, {31'd0, du & ((m_left > 0) | st)});
      check("hiloout",  HILOOut, exp_out);
      check("hi",       HI, m_hi);
      check("lo",       LO, m_lo);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic du);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, du);
  endtask

  task automatic op_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    cyc(1'b0, 1'b1, op, a, b, 1'b0, 1'b0);
    busy_seen = 0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    @(posedge clk); #1;
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    op_run(4'd1, 32'hFFFF_FFFE, 32'd3);
    idle(6, 1'b0);
    check("mult_busy_cycles", busy_seen, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    op_run(4'd2, 32'hFFFF_FFFE, 32'd3);
    idle(6, 1'b0);
    check("multu_hi", HI, 32'h2);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    cyc(1'b0, 1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    busy_seen = 0;
    idle(10, 1'b1);
    check("div_busy_cycles", busy_seen, 32'd10);
    cyc(1'b0, 1'b0, 4'd8, 32'd0, 32'd0, 1'b0, 1'b1);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    op_run(4'd4, 32'd7, 32'd0);
    idle(11, 1'b0);
    check("divu0_busy_cycles", busy_seen, 32'd10);
    check("divu0_hi", HI, 32'hFFFF_FFFF);
    check("divu0_lo", LO, 32'hFFFF_FFFD);

    op_run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(11, 1'b0);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'd0);

    cyc(1'b0, 1'b1, 4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
    check("req_block_busy", {31'd0, Busy}, 32'd0);
    idle(2, 1'b0);

    op_run(4'd1, 32'd6, 32'd7);
    cyc(1'b0, 1'b0, 4'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'd2, 32'd100, 32'd100, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b0, 4'd6, 32'h5555, 32'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("busy_mthi_hi", HI, 32'd0);
    check("busy_mtlo_lo", LO, 32'd42);

    cyc(1'b0, 1'b0, 4'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    check("mthi_idle", HI, 32'h1234);

    op_run(4'd1, 32'd5, 32'd5);
    idle(2, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("reset_mid_busy", {31'd0, Busy}, 32'd0);
    check("reset_mid_hi", HI, 32'd0);
    check("reset_mid_lo", LO, 32'd0);
    idle(8, 1'b0);
    check("reset_mid_lo_stays", LO, 32'd0);

    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      cyc(($urandom_range(0, 79) == 0),
          (op >= 1 && op <= 4) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0),
          op, ra, rb, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1 bit: the E-stage instruction is mult/multu/div/divu.
REQ-004 SHALL have port HILOCtrl, input, 4 bits: E-stage op. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 none.
REQ-005 SHALL have port A, input, 32 bits: rs operand.
REQ-006 SHALL have port B, input, 32 bits: rt operand.
REQ-007 SHALL have port Req, input, 1 bit: exception/interrupt flush of the E-stage instruction this cycle.
REQ-008 SHALL have port DUseMDU, input, 1 bit: the D-stage instruction is any HILOCtrl op 1-8.
REQ-009 SHALL have port Busy, output, 1 bit: a mult/div is in progress.
REQ-010 SHALL have port StallReq, output, 1 bit: stall D stage.
REQ-011 SHALL have port HILOOut, output, 32 bits: mfhi/mflo read data.
REQ-012 SHALL have port HI, output, 32 bits: architectural HI register.
REQ-013 SHALL have port LO, output, 32 bits: architectural LO register.
REQ-014 SHALL use latency parameters MULT_CYC, default 5: mult/multu cycles; DIV_CYC, default 10: div/divu cycles.

Function
REQ-015 SHALL implement states IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-016 SHALL accept an operation (Accept) when state is IDLE, Start=1, Req=0, and HILOCtrl is 1-4.
REQ-017 On Accept at edge t, SHALL compute the 64-bit result from A and B into temporaries tHI/tLO, load cnt with MULT_CYC or DIV_CYC, and enter RUN.
REQ-018 Busy SHALL equal (state==RUN), i.e. 1 for exactly N cycles after the accepting edge, where N is the latency.
REQ-019 In RUN, cnt SHALL decrement each edge; at the edge where cnt==1, SHALL write HI=tHI and LO=tLO and return to IDLE, so Busy falls at the same edge the results appear.
REQ-020 mult: {HI,LO} = signed A*B. multu: {HI,LO} = unsigned A*B.
REQ-021 div: LO = signed quotient truncated toward zero; HI = remainder with the sign of A.
REQ-022 div, A=0x80000000 and B=0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-023 divu: LO = unsigned quotient, HI = unsigned remainder.
REQ-024 Divide by zero (B=0, div or divu): SHALL still run DIV_CYC cycles; HI and LO keep their prior values.
REQ-025 mthi/mtlo: when IDLE and Req=0, SHALL write A into HI or LO at the edge; when Busy or Req=1, SHALL ignore the write.
REQ-026 Start while Busy SHALL be ignored; the in-flight operation is unaffected.
REQ-027 Req=1 SHALL block only a new Accept or mthi/mtlo; an operation already in RUN SHALL complete normally.
REQ-028 HILOOut SHALL be combinational: HI when HILOCtrl=7, LO when HILOCtrl=8, else 0.
REQ-029 StallReq SHALL equal DUseMDU & (Busy | Start), combinational.
REQ-030 An mthi/mtlo at the same edge as a RUN completion SHALL lose; the completion result is written.

Reset
REQ-031 On reset=1 at an edge, SHALL set state=IDLE, cnt=0, HI=0, LO=0, tHI=0, tLO=0.
REQ-032 Reset SHALL take priority over every other input, including mid-operation: the operation is discarded and Busy=0 from the next cycle.
REQ-033 After reset, SHALL hold Busy=0, StallReq=DUseMDU&Start, and HILOOut per REQ-028 with HI=LO=0.

Verification
REQ-034 mult with A=0xFFFFFFFE (-2), B=3 -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same A and B -> HI=0x2, LO=0xFFFFFFFA.
REQ-035 div with A=-7, B=2 -> Busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=0 -> 10 busy cycles; HI and LO unchanged.
REQ-036 Start with Req=1 -> Busy stays 0 and HI/LO unchanged. mthi with A=0x1234 while Busy -> ignored. mthi with A=0x1234 while IDLE -> HI=0x1234 next cycle.
REQ-037 DUseMDU=1 across a div -> StallReq=1 in the Start cycle and all 10 busy cycles, and 0 in the cycle after Busy falls. mflo in that cycle -> HILOOut = new LO.
REQ-038 reset asserted at busy cycle 3 of a mult -> Busy=0 and HI=LO=0 next cycle. A second Start issued during RUN -> ignored, with the original result committed.
